// File: rtl/core_req_agent.sv
// core_req_agent: per-core requester for the butterfly shared-memory network.
// Accepts a core request, issues it as a forward packet, and waits for the
// matching backward packet. Drops are re-issued after an exponential backoff,
// and the result (data or error) is returned to the core.
module core_req_agent #(
    parameter int CORE_ID       = 0,
    parameter int ID_W          = 3,
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 16,
    parameter int PACKET_W      = 1 + ID_W + ADDR_W + DATA_W,
    parameter int BACK_PACKET_W = ID_W + DATA_W,
    parameter int MAX_RETRIES   = 4,
    parameter int BACKOFF_BASE  = 2,
    parameter int TIMEOUT       = 64,
    parameter int STAT_W        = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic [1:0]               resp_err,
    output logic                     pkt_valid,
    output logic [PACKET_W-1:0]      pkt_out,
    input  logic                     back_valid,
    input  logic [BACK_PACKET_W-1:0] back_in,
    input  logic                     dropped,
    output logic                     busy,
    output logic [STAT_W-1:0]        retry_total,
    output logic                     stray
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned BO_W    = $clog2((BACKOFF_BASE << 3) + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_BACKOFF = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [ID_W-1:0]    MY_ID     = ID_W'(CORE_ID);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [BO_W-1:0]    BO_BASE   = BO_W'(BACKOFF_BASE);

    logic [2:0]          state_q, state_d;
    // Holds the formatted request; also the latched we/addr/wdata.
    logic [PACKET_W-1:0] pkt_q, pkt_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [BO_W-1:0]     bo_q, bo_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          err_q, err_d;
    logic [STAT_W-1:0]   total_q, total_d;
    logic                stray_q, stray_d;

    logic                we_lat;
    logic                id_match;
    logic [DATA_W-1:0]   back_data;
    logic [RETRY_W-1:0]  retry_inc;
    logic [1:0]          bo_shift;

    assign we_lat    = pkt_q[PACKET_W-1];
    assign id_match  = (back_in[BACK_PACKET_W-1 -: ID_W] == MY_ID);
    assign back_data = back_in[DATA_W-1:0];
    assign retry_inc = retry_q + RETRY_W'(1);
    // Backoff exponent is (new retry count - 1) == old count, capped at 3.
    assign bo_shift  = (int'(retry_q) >= 3) ? 2'd3 : 2'(retry_q);

    // Next-state and datapath logic for the request FSM.
    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        retry_d = retry_q;
        to_d    = to_q;
        bo_d    = bo_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        total_d = total_q;
        stray_d = stray_q;

        if ((back_valid || dropped) && (state_q != S_WAIT)) begin
            stray_d = 1'b1;
        end
        if ((state_q == S_WAIT) && back_valid && !id_match) begin
            stray_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    pkt_d   = {req_we, MY_ID, req_addr, req_wdata};
                    retry_d = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (back_valid && id_match) begin
                    rdata_d = we_lat ? '0 : back_data;
                    err_d   = 2'b00;
                    state_d = S_RESP;
                end else if (dropped) begin
                    retry_d = retry_inc;
                    if (total_q != '1) begin
                        total_d = total_q + STAT_W'(1);
                    end
                    if (retry_inc == RETRY_MAX) begin
                        rdata_d = '0;
                        err_d   = 2'b01;
                        state_d = S_RESP;
                    end else begin
                        bo_d    = BO_BASE << bo_shift;
                        state_d = S_BACKOFF;
                    end
                end else if (to_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 2'b10;
                    state_d = S_RESP;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_BACKOFF: begin
                bo_d = bo_q - BO_W'(1);
                if (bo_q <= BO_W'(1)) begin
                    state_d = S_SEND;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pkt_q   <= '0;
            retry_q <= '0;
            to_q    <= '0;
            bo_q    <= '0;
            rdata_q <= '0;
            err_q   <= '0;
            total_q <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            retry_q <= retry_d;
            to_q    <= to_d;
            bo_q    <= bo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            total_q <= total_d;
            stray_q <= stray_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_RESP);
    assign pkt_valid   = (state_q == S_SEND);
    assign busy        = (state_q != S_IDLE);
    assign pkt_out     = pkt_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign retry_total = total_q;
    assign stray       = stray_q;

endmodule
